// File: rtl/alu_exec_pipe.sv
// Two-stage integer ALU execution pipe: EX holds the issued operands, the ALU
// sits combinationally between EX and WB, and WB holds the registered result
// that is broadcast on the CDB until it is granted.
module alu_exec_pipe #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      issue_ready,
  input  logic [3:0]                insn_in,
  input  logic [XLEN-1:0]           opa_in,
  input  logic [XLEN-1:0]           opb_in,
  input  logic [REG_ADDR_WIDTH-1:0] dst_in,
  output logic                      issue,
  input  logic                      flush,
  input  logic                      cdb_grant,
  output logic                      cdb_valid,
  output logic [REG_ADDR_WIDTH-1:0] cdb_tag,
  output logic [XLEN-1:0]           cdb_value
);

  // Operation encodings of the ALU1 function field.
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  // Wrapping ALU; unknown encodings produce zero.
  function automatic logic [XLEN-1:0] alu_op(input logic [3:0]      op,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic        [4:0]      sh;
    sa = a;
    sb = b;
    sh = b[4:0];
    case (op)
      ALU_ADD:  alu_op = a + b;
      ALU_SUB:  alu_op = a - b;
      ALU_AND:  alu_op = a & b;
      ALU_OR:   alu_op = a | b;
      ALU_XOR:  alu_op = a ^ b;
      ALU_SLL:  alu_op = a << sh;
      ALU_SRL:  alu_op = a >> sh;
      ALU_SRA:  alu_op = sa >>> sh;
      ALU_SLT:  alu_op = {{(XLEN-1){1'b0}}, (sa < sb)};
      ALU_SLTU: alu_op = {{(XLEN-1){1'b0}}, (a < b)};
      default:  alu_op = '0;
    endcase
  endfunction

  // EX stage (p0): issued instruction and operands
  logic                      vld_p0;
  logic [3:0]                insn_p0;
  logic [XLEN-1:0]           opa_p0;
  logic [XLEN-1:0]           opb_p0;
  logic [REG_ADDR_WIDTH-1:0] dst_p0;
  logic [XLEN-1:0]           res_p0;

  // WB stage (p1): registered result on the CDB
  logic                      vld_p1;
  logic [REG_ADDR_WIDTH-1:0] dst_p1;
  logic [XLEN-1:0]           res_p1;

  logic wb_adv;
  logic ex_adv;

  // A stage may advance when it is empty or its successor drains.
  assign wb_adv = ~vld_p1 | cdb_grant;
  assign ex_adv = ~vld_p0 | wb_adv;
  assign issue  = issue_ready & ex_adv & ~flush & ~reset;

  // EX valid: set by an issue, cleared when EX drains with nothing new.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      vld_p0 <= 1'b0;
    end else if (ex_adv) begin
      vld_p0 <= issue;
    end
  end

  // EX payload is captured only on an accepted issue.
  always_ff @(posedge clk) begin
    if (issue) begin
      insn_p0 <= insn_in;
      opa_p0  <= opa_in;
      opb_p0  <= opb_in;
      dst_p0  <= dst_in;
    end
  end

  // ALU between EX and WB.
  always_comb begin
    res_p0 = alu_op(insn_p0, opa_p0, opb_p0);
  end

  // ---- EX -> WB boundary ----

  // WB valid: follows EX when advancing, holds while the CDB stalls.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      vld_p1 <= 1'b0;
    end else if (wb_adv) begin
      vld_p1 <= vld_p0;
    end
  end

  // WB payload: zeroed by reset so the bus reads clean, held while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      dst_p1 <= '0;
      res_p1 <= '0;
    end else if (wb_adv && !flush) begin
      dst_p1 <= dst_p0;
      res_p1 <= res_p0;
    end
  end

  assign cdb_valid = vld_p1;
  assign cdb_tag   = dst_p1;
  assign cdb_value = res_p1;

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Self-checking bench for alu_exec_pipe: directed vector table, hand-written
// stall/flush/reset sequences, and a randomized run against a queue model.
module tb_alu_exec_pipe;

  logic        clk;
  logic        reset;
  logic        issue_ready;
  logic [3:0]  insn_in;
  logic [31:0] opa_in;
  logic [31:0] opb_in;
  logic [4:0]  dst_in;
  logic        issue;
  logic        flush;
  logic        cdb_grant;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_value;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] val;
  } exp_t;

  vec_t vecs[12];
  exp_t q[$];

  alu_exec_pipe #(.XLEN(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .issue_ready(issue_ready), .insn_in(insn_in),
    .opa_in(opa_in), .opb_in(opb_in), .dst_in(dst_in), .issue(issue),
    .flush(flush), .cdb_grant(cdb_grant), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_value(cdb_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: got running, required finished");
    $fatal(1, "timeout");
  end

  // Reference ALU written from the operation definitions.
  function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ext;
    int unsigned sh;
    sh = b % 32;
    ext = {{32{a[31]}}, a};
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << sh;
      4'd6: return a >> sh;
      4'd7: return ext[31:0] >> 0 == 0 ? 32'd0 : 32'(ext >> sh);
      4'd8: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, then wait for the
  // falling edge where outputs are sampled.
  task automatic drive(input logic ir, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] d, input logic g,
                       input logic fl, input logic rs);
    @(posedge clk);
    #1;
    issue_ready = ir;
    insn_in     = op;
    opa_in      = a;
    opb_in      = b;
    dst_in      = d;
    cdb_grant   = g;
    flush       = fl;
    reset       = rs;
    @(negedge clk);
  endtask

  task automatic idle(input logic g);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, g, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    int nv;
    logic exp_iss;
    logic ir, g, fl;
    logic [3:0] op;
    logic [31:0] a, b;
    logic [4:0] d;
    exp_t e;

    issue_ready = 1'b0; insn_in = '0; opa_in = '0; opb_in = '0; dst_in = '0;
    cdb_grant = 1'b0; flush = 1'b0; reset = 1'b1;

    vecs[0]  = '{4'd0,  32'd5,        32'd7,        32'd12};
    vecs[1]  = '{4'd0,  32'hFFFFFFFF, 32'd2,        32'd1};
    vecs[2]  = '{4'd1,  32'd0,        32'd1,        32'hFFFFFFFF};
    vecs[3]  = '{4'd2,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000};
    vecs[4]  = '{4'd3,  32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0};
    vecs[5]  = '{4'd4,  32'h0000F0F0, 32'h0000FF00, 32'h00000FF0};
    vecs[6]  = '{4'd5,  32'd1,        32'h0000003F, 32'h80000000};
    vecs[7]  = '{4'd6,  32'h80000000, 32'd4,        32'h08000000};
    vecs[8]  = '{4'd7,  32'h80000000, 32'd4,        32'hF8000000};
    vecs[9]  = '{4'd8,  32'hFFFFFFFF, 32'd1,        32'd1};
    vecs[10] = '{4'd9,  32'hFFFFFFFF, 32'd1,        32'd0};
    vecs[11] = '{4'd15, 32'h12345678, 32'd9,        32'd0};
    nv = 12;

    // Reset holds issue low and clears the bus.
    drive(1'b1, 4'd0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 4'd0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 1'b1);
    chk("reset_issue", 32'(issue), 32'd0);
    chk("reset_valid", 32'(cdb_valid), 32'd0);
    chk("reset_tag", 32'(cdb_tag), 32'd0);
    chk("reset_value", cdb_value, 32'd0);

    // First issue right after reset; result two cycles later.
    drive(1'b1, 4'd0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0);
    chk("first_issue", 32'(issue), 32'd1);
    idle(1'b1);
    chk("lat_n1_valid", 32'(cdb_valid), 32'd0);
    idle(1'b1);
    chk("lat_n2_valid", 32'(cdb_valid), 32'd1);
    chk("lat_n2_tag", 32'(cdb_tag), 32'd3);
    chk("lat_n2_value", cdb_value, 32'd12);

    // Vector table streamed back to back with grant held high.
    for (int i = 0; i < nv + 2; i++) begin
      if (i < nv)
        drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), 1'b1, 1'b0, 1'b0);
      else
        idle(1'b1);
      chk($sformatf("vec_issue_%0d", i), 32'(issue), (i < nv) ? 32'd1 : 32'd0);
      if (i >= 2) begin
        chk($sformatf("vec_valid_%0d", i - 2), 32'(cdb_valid), 32'd1);
        chk($sformatf("vec_tag_%0d", i - 2), 32'(cdb_tag), 32'(i - 1));
        chk($sformatf("vec_value_%0d", i - 2), cdb_value, vecs[i - 2].exp);
      end
    end
    idle(1'b1);
    chk("vec_drained", 32'(cdb_valid), 32'd0);

    // CDB stall: two accepted, then issue blocked with a stable bus.
    drive(1'b1, 4'd0, 32'd20, 32'd100, 5'd20, 1'b0, 1'b0, 1'b0);
    chk("stall_issue1", 32'(issue), 32'd1);
    drive(1'b1, 4'd0, 32'd21, 32'd100, 5'd21, 1'b0, 1'b0, 1'b0);
    chk("stall_issue2", 32'(issue), 32'd1);
    drive(1'b1, 4'd0, 32'd22, 32'd100, 5'd22, 1'b0, 1'b0, 1'b0);
    chk("stall_issue3", 32'(issue), 32'd0);
    chk("stall_tag3", 32'(cdb_tag), 32'd20);
    drive(1'b1, 4'd0, 32'd22, 32'd100, 5'd22, 1'b0, 1'b0, 1'b0);
    chk("stall_issue4", 32'(issue), 32'd0);
    chk("stall_valid4", 32'(cdb_valid), 32'd1);
    chk("stall_tag4", 32'(cdb_tag), 32'd20);
    chk("stall_value4", cdb_value, 32'd120);
    drive(1'b1, 4'd0, 32'd22, 32'd100, 5'd22, 1'b1, 1'b0, 1'b0);
    chk("resume_issue", 32'(issue), 32'd1);
    idle(1'b1);
    chk("resume_tag21", 32'(cdb_tag), 32'd21);
    idle(1'b1);
    chk("resume_tag22", 32'(cdb_tag), 32'd22);
    chk("resume_value22", cdb_value, 32'd122);
    idle(1'b1);
    chk("resume_drained", 32'(cdb_valid), 32'd0);

    // Flush with both stages full, even with grant asserted.
    drive(1'b1, 4'd0, 32'd1, 32'd1, 5'd30, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'd0, 32'd1, 32'd1, 5'd31, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'd0, 32'd1, 32'd1, 5'd29, 1'b1, 1'b1, 1'b0);
    chk("flush_issue", 32'(issue), 32'd0);
    chk("flush_pre_tag", 32'(cdb_tag), 32'd30);
    idle(1'b1);
    chk("flush_valid1", 32'(cdb_valid), 32'd0);
    idle(1'b1);
    chk("flush_valid2", 32'(cdb_valid), 32'd0);

    // Reset while WB holds tag 9.
    drive(1'b1, 4'd0, 32'd1, 32'd2, 5'd9, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'd0, 32'd1, 32'd2, 5'd10, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'd0, 32'd1, 32'd2, 5'd11, 1'b0, 1'b0, 1'b1);
    chk("rst_mid_issue", 32'(issue), 32'd0);
    chk("rst_mid_pre_tag", 32'(cdb_tag), 32'd9);
    idle(1'b1);
    chk("rst_mid_valid", 32'(cdb_valid), 32'd0);
    chk("rst_mid_tag", 32'(cdb_tag), 32'd0);
    chk("rst_mid_value", cdb_value, 32'd0);
    idle(1'b1);
    chk("rst_mid_valid2", 32'(cdb_valid), 32'd0);

    // Randomized run against an occupancy-count and in-order queue model.
    n = 0;
    q.delete();
    for (int c = 0; c < 2000; c++) begin
      ir = ($urandom_range(0, 3) != 0);
      g  = ($urandom_range(0, 9) < 7);
      fl = ($urandom_range(0, 39) == 0);
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40));
      d  = 5'($urandom_range(0, 31));
      drive(ir, op, a, b, d, g, fl, 1'b0);
      exp_iss = ir & ~fl & ((n < 2) | g);
      chk("rnd_issue", 32'(issue), 32'(exp_iss));
      if (n == 0) chk("rnd_idle_valid", 32'(cdb_valid), 32'd0);
      if (n == 2) chk("rnd_full_valid", 32'(cdb_valid), 32'd1);
      if (cdb_valid && g) begin
        if (q.size() == 0) begin
          chk("rnd_spurious", 32'(cdb_valid), 32'd0);
        end else begin
          e = q.pop_front();
          chk("rnd_tag", 32'(cdb_tag), 32'(e.tag));
          chk("rnd_value", cdb_value, e.val);
          n--;
        end
      end
      if (fl) begin
        q.delete();
        n = 0;
      end else if (exp_iss) begin
        q.push_back('{d, ref_alu(op, a, b)});
        n++;
      end
    end
    for (int c = 0; c < 4; c++) begin
      idle(1'b1);
      if (cdb_valid && q.size() != 0) begin
        e = q.pop_front();
        chk("drain_tag", 32'(cdb_tag), 32'(e.tag));
        chk("drain_value", cdb_value, e.val);
      end
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
    chk("drain_valid", 32'(cdb_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_pipe.md
ALU_EXEC_PIPE -- requirements
Module: alu_exec_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning operand and result width.
REQ-002 The block SHALL have parameter REG_ADDR_WIDTH, default 5, meaning destination tag width.
REQ-003 The block SHALL have port clk, input, 1 bit; the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-005 The block SHALL have port issue_ready, input, 1 bit; the issue queue holds an issuable instruction.
REQ-006 The block SHALL have port insn_in, input, ALU1_FUNC; the operation of the offered instruction.
REQ-007 The block SHALL have port opa_in, input, XLEN; operand A value.
REQ-008 The block SHALL have port opb_in, input, XLEN; operand B value.
REQ-009 The block SHALL have port dst_in, input, REG_ADDR_WIDTH; the destination tag.
REQ-010 The block SHALL have port issue, output, 1 bit; the pop request to the issue queue.
REQ-011 The block SHALL have port flush, input, 1 bit; squashes all in-flight work.
REQ-012 The block SHALL have port cdb_grant, input, 1 bit; the CDB accepts the current broadcast.
REQ-013 The block SHALL have port cdb_valid, output, 1 bit; a broadcast is pending.
REQ-014 The block SHALL have port cdb_tag, output, REG_ADDR_WIDTH; the broadcast destination tag.
REQ-015 The block SHALL have port cdb_value, output, XLEN; the broadcast result.

Function
REQ-016 The block SHALL be a two-stage pipeline, EX (operand register) then WB (result register), each with its own valid bit.
REQ-017 WB SHALL advance (wb_adv) when WB is empty or cdb_grant=1; EX SHALL advance (ex_adv) when EX is empty or wb_adv=1.
REQ-018 issue SHALL be combinational: issue = issue_ready & ex_adv & ~flush & ~reset.
REQ-019 At an edge with issue=1, EX SHALL capture insn_in, opa_in, opb_in and dst_in and set its valid bit.
REQ-020 At an edge with ex_adv=1 and issue=0, the EX valid bit SHALL clear.
REQ-021 At an edge with wb_adv=1, WB SHALL load the EX result, EX tag and EX valid bit.
REQ-022 If wb_adv=0, WB SHALL hold, and cdb_valid, cdb_tag and cdb_value SHALL remain stable until the grant.
REQ-023 Latency SHALL be: issue high in cycle N gives cdb_valid high in cycle N+2 when no stall occurs.
REQ-024 Throughput SHALL be one instruction per cycle while cdb_grant=1 continuously.
REQ-025 cdb_grant=1 while cdb_valid=0 SHALL be ignored.
REQ-026 Operations SHALL compute:
  - ADD: a+b
  - SUB: a-b
  - AND, OR, XOR: bitwise
  - SLL, SRL: logical shift by b[4:0]
  - SRA: arithmetic shift by b[4:0]
  - SLT: signed compare, result 1/0
  - SLTU: unsigned compare, result 1/0
  - any other encoding: result 0
REQ-027 Arithmetic SHALL wrap modulo 2^XLEN, with no overflow flag.
REQ-028 cdb_value SHALL be registered; the ALU SHALL sit between EX and WB.
REQ-029 Full condition: when both stages are valid and cdb_grant=0, issue SHALL be 0 and no state SHALL change.
REQ-030 Simultaneous grant and issue while full SHALL be legal: WB takes the EX result, EX takes the new instruction, and nothing is lost.
REQ-031 At an edge with flush=1, both valid bits SHALL clear, and no instruction SHALL be captured that cycle.
REQ-032 flush SHALL take priority over grant; a granted result in the flush cycle is still considered consumed by the CDB.

Reset
REQ-033 At an edge with reset=1, the EX and WB valid bits SHALL clear, cdb_tag and cdb_value SHALL become 0, and issue SHALL be 0 while reset is high.
REQ-034 reset asserted mid-operation SHALL discard all in-flight instructions, with no broadcast afterwards.
REQ-035 The first issue SHALL be possible in the first cycle after reset deasserts.

Verification
REQ-036 Reset, then issue_ready=1 with ADD, opa=5, opb=7, dst=3, and grant=1 -> issue=1 in cycle N; cdb_valid=1, tag=3, value=12 in N+2.
REQ-037 SUB 0-1, SRA 0x80000000 by 4, and SLT -1<1 -> results 0xFFFFFFFF, 0xF8000000 and 1 respectively.
REQ-038 Four back-to-back ADDs with grant=1 throughout -> four broadcasts in four consecutive cycles, in order.
REQ-039 grant=0 for 3 cycles with issue_ready=1 -> exactly 2 instructions accepted, then issue=0 and outputs stable; raising grant resumes issue in the same cycle.
REQ-040 Both stages full, then flush=1 -> cdb_valid=0 next cycle, no stale tag broadcast, and issue=0 during the flush cycle.
REQ-041 reset=1 while WB holds tag 9 -> cdb_valid=0, cdb_tag=0 and cdb_value=0 after the edge, and tag 9 is never granted.
